// File: rtl/iter_div32.sv
// iter_div32: iterative unsigned restoring divider with valid/ready handshakes on both sides.
// One quotient bit per clock; a zero divisor short-circuits to q = all ones, r = a, div0 = 1.
module iter_div32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div0,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] dvd, dvs, rem, nrem, ndvd;
  logic [WIDTH:0] t, diff;
  logic ge;
  logic [CW-1:0] cnt;
  // rem < divisor always holds, so the sign of t - divisor alone decides t >= divisor
  always_comb begin
    t = {rem, dvd[WIDTH-1]};
    diff = t - {1'b0, dvs};
    ge = ~diff[WIDTH];
    nrem = ge ? diff[WIDTH-1:0] : t[WIDTH-1:0];
    ndvd = {dvd[WIDTH-2:0], ge};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      busy <= 1'b0;
      q <= '0;
      r <= '0;
      div0 <= 1'b0;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          dvd <= a;
          dvs <= b;
          rem <= '0;
          cnt <= '0;
          in_ready <= 1'b0;
          if (b == '0) begin
            state <= DONE;
            q <= '1;
            r <= a;
            div0 <= 1'b1;
          end else begin
            state <= BUSY;
            busy <= 1'b1;
          end
        end
        BUSY: begin
          rem <= nrem;
          dvd <= ndvd;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            busy <= 1'b0;
            out_valid <= 1'b1;
            q <= ndvd;
            r <= nrem;
            div0 <= 1'b0;
          end
        end
        // divide-by-zero enters with out_valid low and raises it one cycle later
        DONE: if (!out_valid) out_valid <= 1'b1;
        else if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_div32.sv
// tb_iter_div32: directed and random checks of iter_div32 against plain-arithmetic division.
module tb_iter_div32;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic in_ready, out_valid, div0, busy;
  logic [31:0] q, r;
  int vectors = 0, miscompares = 0;

  iter_div32 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .q(q), .r(r), .div0(div0), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [31:0] av, input logic [31:0] bv, input int stall, input bit noise);
    int n, bz;
    logic [31:0] eq, er, hq, hr;
    n = 0;
    while (!in_ready && n < 64) begin
      tick();
      n++;
    end
    chk("in_ready_before", 64'(in_ready), 64'd1);
    eq = (bv == 0) ? 32'hFFFF_FFFF : av / bv;
    er = (bv == 0) ? av : av % bv;
    a = av;
    b = bv;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    tick();
    in_valid = 1'b0;
    n = 0;
    bz = 0;
    while (!out_valid && n < 100) begin
      bz += int'(busy);
      if (noise) begin
        a = $urandom;
        b = $urandom;
        in_valid = n[0];
      end
      tick();
      n++;
    end
    chk("latency", 64'(n), (bv == 0) ? 64'd1 : 64'd32);
    chk("busy_cycles", 64'(bz), (bv == 0) ? 64'd0 : 64'd32);
    chk("q", 64'(q), 64'(eq));
    chk("r", 64'(r), 64'(er));
    chk("div0", 64'(div0), 64'(bv == 0));
    if (bv != 0) chk("q_times_b_plus_r", {32'b0, q} * {32'b0, bv} + {32'b0, r}, {32'b0, av});
    hq = q;
    hr = r;
    for (int i = 0; i < stall; i++) begin
      if (noise) begin
        a = $urandom;
        b = $urandom;
        in_valid = ~in_valid;
      end
      tick();
      chk("hold_qr", {q, r}, {hq, hr});
      chk("hold_flags", 64'({in_ready, out_valid}), 64'b01);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release", 64'({in_ready, out_valid, busy}), 64'b100);
  endtask

  initial begin
    logic [31:0] av, bv;
    tick();
    chk("rst_flags", 64'({in_ready, out_valid, busy, div0}), 64'b1000);
    chk("rst_qr", {q, r}, 64'd0);
    rst = 1'b0;
    tick();
    op(32'd100, 32'd7, 0, 1'b0);
    op(32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    op(32'h8000_0000, 32'd3, 0, 1'b0);
    op(32'd3, 32'd10, 0, 1'b0);
    op(32'd5, 32'd0, 0, 1'b0);
    op(32'd100, 32'd7, 10, 1'b1);
    // abort a division halfway with an asynchronous reset
    a = 32'hB049_55A2;
    b = 32'h0000_1234;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (15) tick();
    chk("midrst_busy_before", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_flags", 64'({in_ready, out_valid, busy, div0}), 64'b1000);
    chk("midrst_qr", {q, r}, 64'd0);
    tick();
    rst = 1'b0;
    op(32'd100, 32'd7, 0, 1'b0);
    for (int k = 0; k < 200; k++) begin
      av = $urandom;
      do bv = $urandom >> $urandom_range(0, 31); while (bv == 0);
      op(av, bv, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
